// File: rtl/constant_load_encoder_pkg.sv
// Shared RV32I encoding constants and state type for the constant-load encoder.
// The compressed (shortcut) sequences are enabled with JZJCOREF_LI_COMPRESS_EN.
package JZJCoreFTypes;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [2:0] FUNCT3_ADDI   = 3'b000;
    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        EMIT_UPPER,
        EMIT_LOWER
    } ConstantLoadState_t;

    typedef struct packed {
        logic [19:0] hi20;
        logic [11:0] lo12;
        logic        skip_upper;
        logic        skip_lower;
    } split_t;
endpackage

// File: rtl/constant_load_encoder_split.sv
// Combinational split of a constant (or PC-relative offset) into LUI/AUIPC + ADDI fields.
// Skip flags are only produced when JZJCOREF_LI_COMPRESS_EN is defined.
module constant_split
    import JZJCoreFTypes::*;
(
    input  logic [31:0] value,
    input  logic [31:0] pc,
    input  logic        pc_relative,
    output split_t      split
);
    logic [31:0] off;

    always_comb begin
        off = pc_relative ? (value - pc) : value;
        split = '0;
        // Rounding up by off[11] compensates for ADDI sign-extending lo12; wraps mod 2^20.
        split.hi20 = off[31:12] + {19'b0, off[11]};
        split.lo12 = off[11:0];
`ifdef JZJCOREF_LI_COMPRESS_EN
        split.skip_upper = !pc_relative && (split.hi20 == 20'd0);
        split.skip_lower = (split.lo12 == 12'd0);
`endif
    end
endmodule

// File: rtl/constant_load_encoder.sv
// Encodes a 32-bit constant or PC-relative target into an LUI/AUIPC + ADDI stream.
// Optional single-word shortcuts are enabled with JZJCOREF_LI_COMPRESS_EN.
module constant_load_encoder
    import JZJCoreFTypes::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_value,
    input  logic        req_pc_relative,
    input  logic [31:0] req_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_word,
    output logic        instr_last
);
    ConstantLoadState_t state, state_nxt;
    split_t             split;
    logic [31:0]        upper_word, lower_word, lower_q;
    logic [31:0]        lower_nxt, word_nxt;
    logic               valid_nxt, last_nxt;
    logic               skip_upper, skip_lower;

    constant_split u_split (
        .value       (req_value),
        .pc          (req_pc),
        .pc_relative (req_pc_relative),
        .split       (split)
    );

    always_comb begin
        upper_word = {split.hi20, req_rd, req_pc_relative ? OPCODE_AUIPC : OPCODE_LUI};
`ifdef JZJCOREF_LI_COMPRESS_EN
        // rd==x0 collapses to a lone NOP regardless of the value.
        skip_upper = (req_rd == 5'd0) || split.skip_upper;
        skip_lower = !skip_upper && split.skip_lower;
        if (req_rd == 5'd0)
            lower_word = INSTR_NOP;
        else
            lower_word = {split.lo12, skip_upper ? 5'd0 : req_rd, FUNCT3_ADDI, req_rd, OPCODE_OP_IMM};
`else
        skip_upper = 1'b0;
        skip_lower = 1'b0;
        lower_word = {split.lo12, req_rd, FUNCT3_ADDI, req_rd, OPCODE_OP_IMM};
`endif
    end

    assign req_ready = (state == IDLE) && reset;

    always_comb begin
        state_nxt = state;
        valid_nxt = instr_valid;
        word_nxt  = instr_word;
        last_nxt  = instr_last;
        lower_nxt = lower_q;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    valid_nxt = 1'b1;
                    lower_nxt = lower_word;
                    if (skip_upper) begin
                        word_nxt  = lower_word;
                        last_nxt  = 1'b1;
                        state_nxt = EMIT_LOWER;
                    end else begin
                        word_nxt  = upper_word;
                        last_nxt  = skip_lower;
                        state_nxt = EMIT_UPPER;
                    end
                end
            end
            EMIT_UPPER: begin
                if (instr_ready) begin
                    if (instr_last) begin
                        valid_nxt = 1'b0;
                        word_nxt  = '0;
                        last_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        word_nxt  = lower_q;
                        last_nxt  = 1'b1;
                        state_nxt = EMIT_LOWER;
                    end
                end
            end
            EMIT_LOWER: begin
                if (instr_ready) begin
                    valid_nxt = 1'b0;
                    word_nxt  = '0;
                    last_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                valid_nxt = 1'b0;
                word_nxt  = '0;
                last_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            instr_valid <= 1'b0;
            instr_word  <= '0;
            instr_last  <= 1'b0;
            lower_q     <= '0;
        end else begin
            state       <= state_nxt;
            instr_valid <= valid_nxt;
            instr_word  <= word_nxt;
            instr_last  <= last_nxt;
            lower_q     <= lower_nxt;
        end
    end
endmodule
